// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: button-driven fine/coarse frequency ladder with a bounded
// learn-mode sweep, producing a registered DDS tuning word in the clk_50m domain.
module freq_sweep_ctrl #(
   parameter int FREQ_W      = 16,
   parameter int TW_W        = 24,
   parameter int FINE_MAX    = 30,
   parameter int COARSE_STEP = 15000,
   parameter int COARSE_N    = 3,
   parameter int SWEEP_START = 1000,
   parameter int SWEEP_STEP  = 2,
   parameter int SWEEP_STOP  = 45000
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic [1:0]        key,
   input  logic              learn_en,
   input  logic              next_freq,
   output logic [FREQ_W-1:0] freq_out,
   output logic [TW_W-1:0]   tuning_word,
   output logic              tw_valid,
   output logic              learn_mode,
   output logic              sweep_done
);

   // Wide enough to hold freq*10 + (freq+2)/4 without overflow before truncation.
   localparam int CALC_W = ((FREQ_W + 5) > TW_W) ? (FREQ_W + 5) : TW_W;

   localparam logic [FREQ_W-1:0] ONE_C      = FREQ_W'(1);
   localparam logic [FREQ_W-1:0] FINE_MAX_C = FREQ_W'(FINE_MAX);
   localparam logic [FREQ_W-1:0] COARSE_C   = FREQ_W'(COARSE_STEP);
   localparam logic [FREQ_W-1:0] TOP_C      = FREQ_W'(COARSE_N * COARSE_STEP);
   localparam logic [FREQ_W-1:0] START_C    = FREQ_W'(SWEEP_START);
   localparam logic [FREQ_W-1:0] STOP_C     = FREQ_W'(SWEEP_STOP);
   localparam logic [FREQ_W:0]   STOP_WIDE_C = (FREQ_W+1)'(SWEEP_STOP);
   localparam logic [FREQ_W:0]   STEP_WIDE_C = (FREQ_W+1)'(SWEEP_STEP);
   localparam logic [TW_W-1:0]   TW_RESET_C  = TW_W'(10);

   typedef enum logic [0:0] {NORM = 1'b0, LEARN = 1'b1} state_t;

   state_t            state_r;
   logic [FREQ_W-1:0] hold_r;

   logic [1:0] key_s1_r, key_s2_r, key_d_r;
   logic       learn_s1_r, learn_s2_r, learn_d_r;
   logic       next_s1_r, next_s2_r, next_d_r;

   logic              down_press_s, up_press_s;
   logic              learn_rise_s, learn_fall_s, next_rise_s;
   logic [FREQ_W:0]   sweep_sum_s;
   logic              sweep_hit_s;
   logic [FREQ_W-1:0] sweep_next_s;
   logic [TW_W-1:0]   tw_next_s;

   // Next ladder value for a down press.
   function automatic logic [FREQ_W-1:0] ladder_down(input logic [FREQ_W-1:0] f);
      logic [FREQ_W-1:0] r;
      r = TOP_C;
      if (f <= ONE_C) begin
         r = FINE_MAX_C;
      end else if (f <= FINE_MAX_C) begin
         r = f - ONE_C;
      end else if (f == COARSE_C) begin
         r = FINE_MAX_C;
      end else begin
         for (int k = 2; k <= COARSE_N; k++) begin
            if (f == FREQ_W'(k * COARSE_STEP)) begin
               r = FREQ_W'((k - 1) * COARSE_STEP);
            end else begin
               r = r;
            end
         end
      end
      return r;
   endfunction

   // Next ladder value for an up press.
   function automatic logic [FREQ_W-1:0] ladder_up(input logic [FREQ_W-1:0] f);
      logic [FREQ_W-1:0] r;
      r = FINE_MAX_C;
      if (f < FINE_MAX_C) begin
         r = f + ONE_C;
      end else if (f == FINE_MAX_C) begin
         r = COARSE_C;
      end else begin
         for (int k = 1; k <= COARSE_N; k++) begin
            if (f == FREQ_W'(k * COARSE_STEP)) begin
               if (k == COARSE_N) begin
                  r = f;
               end else begin
                  r = FREQ_W'((k + 1) * COARSE_STEP);
               end
            end else begin
               r = r;
            end
         end
      end
      return r;
   endfunction

   // Two-flop synchronisers plus one edge-history register per input.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_r   <= 2'b11;
         key_s2_r   <= 2'b11;
         key_d_r    <= 2'b11;
         learn_s1_r <= 1'b0;
         learn_s2_r <= 1'b0;
         learn_d_r  <= 1'b0;
         next_s1_r  <= 1'b0;
         next_s2_r  <= 1'b0;
         next_d_r   <= 1'b0;
      end else begin
         key_s1_r   <= key;
         key_s2_r   <= key_s1_r;
         key_d_r    <= key_s2_r;
         learn_s1_r <= learn_en;
         learn_s2_r <= learn_s1_r;
         learn_d_r  <= learn_s2_r;
         next_s1_r  <= next_freq;
         next_s2_r  <= next_s1_r;
         next_d_r   <= next_s2_r;
      end
   end

   assign down_press_s = key_d_r[0] & ~key_s2_r[0];
   assign up_press_s   = key_d_r[1] & ~key_s2_r[1];
   assign learn_rise_s = learn_s2_r & ~learn_d_r;
   assign learn_fall_s = ~learn_s2_r & learn_d_r;
   assign next_rise_s  = next_s2_r & ~next_d_r;

   // Sweep step saturating at the stop limit; extra bit guards against wrap.
   always_comb begin
      sweep_sum_s  = {1'b0, freq_out} + STEP_WIDE_C;
      sweep_hit_s  = 1'b0;
      sweep_next_s = sweep_sum_s[FREQ_W-1:0];
      if (sweep_sum_s >= STOP_WIDE_C) begin
         sweep_hit_s  = 1'b1;
         sweep_next_s = STOP_C;
      end else begin
         sweep_hit_s  = 1'b0;
      end
   end

   // Tuning word computed at full width then truncated to the DDS width.
   assign tw_next_s = TW_W'((CALC_W'(freq_out) * CALC_W'(10))
                            + ((CALC_W'(freq_out) + CALC_W'(2)) >> 2));

   // Mode FSM: ladder stepping in NORM, bounded sweep in LEARN.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= NORM;
         freq_out   <= ONE_C;
         hold_r     <= ONE_C;
         learn_mode <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         case (state_r)
            NORM: begin
               if (learn_rise_s) begin
                  hold_r     <= freq_out;
                  freq_out   <= START_C;
                  state_r    <= LEARN;
                  learn_mode <= 1'b1;
               end else if (down_press_s) begin
                  freq_out <= ladder_down(freq_out);
               end else if (up_press_s) begin
                  freq_out <= ladder_up(freq_out);
               end
            end
            LEARN: begin
               if (learn_fall_s) begin
                  freq_out   <= hold_r;
                  state_r    <= NORM;
                  learn_mode <= 1'b0;
                  sweep_done <= 1'b0;
               end else if (next_rise_s) begin
                  freq_out <= sweep_next_s;
                  if (sweep_hit_s) begin
                     sweep_done <= 1'b1;
                  end
               end
            end
            default: begin
               state_r    <= NORM;
               learn_mode <= 1'b0;
               sweep_done <= 1'b0;
            end
         endcase
      end
   end

   // Tuning word register and change pulse, one cycle behind freq_out.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         tuning_word <= TW_RESET_C;
         tw_valid    <= 1'b0;
      end else begin
         tuning_word <= tw_next_s;
         tw_valid    <= (tw_next_s != tuning_word);
      end
   end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl: ladder, learn sweep, stop limit,
// simultaneous events and reset, with hand-computed expectations.
module tb_freq_sweep_ctrl;

   logic        clk_50m;
   logic        rst_n;
   logic [1:0]  key;
   logic        learn_en;
   logic        next_freq;

   logic [15:0] freq_out,   freq_out_s;
   logic [23:0] tuning_word, tuning_word_s;
   logic        tw_valid,   tw_valid_s;
   logic        learn_mode, learn_mode_s;
   logic        sweep_done, sweep_done_s;

   int vec_cnt = 0;
   int err_cnt = 0;

   freq_sweep_ctrl dut (
      .clk_50m(clk_50m), .rst_n(rst_n), .key(key), .learn_en(learn_en),
      .next_freq(next_freq), .freq_out(freq_out), .tuning_word(tuning_word),
      .tw_valid(tw_valid), .learn_mode(learn_mode), .sweep_done(sweep_done)
   );

   freq_sweep_ctrl #(.SWEEP_STOP(1010)) dut_s (
      .clk_50m(clk_50m), .rst_n(rst_n), .key(key), .learn_en(learn_en),
      .next_freq(next_freq), .freq_out(freq_out_s), .tuning_word(tuning_word_s),
      .tw_valid(tw_valid_s), .learn_mode(learn_mode_s), .sweep_done(sweep_done_s)
   );

   initial clk_50m = 1'b0;
   always #10 clk_50m = ~clk_50m;

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk_50m);
   endtask

   // m bit set = that key pressed (pins are active-low).
   task automatic press(input logic [1:0] m);
      key = ~m;
      wait_neg(4);
      key = 2'b11;
      wait_neg(4);
   endtask

   task automatic pulse_next();
      next_freq = 1'b1;
      wait_neg(4);
      next_freq = 1'b0;
      wait_neg(4);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wait_neg(2);
      rst_n = 1'b1;
      wait_neg(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_neg(3);
      vec_cnt++; if (freq_out !== 16'd1) begin $display("FAIL rst_freq: got %0d expected 1", freq_out); err_cnt++; end
      vec_cnt++; if (tuning_word !== 24'd10) begin $display("FAIL rst_tw: got %0d expected 10", tuning_word); err_cnt++; end
      rst_n = 1'b1;
      wait_neg(3);
      vec_cnt++; if (freq_out !== 16'd1) begin $display("FAIL idle_freq: got %0d expected 1", freq_out); err_cnt++; end
      vec_cnt++; if (tuning_word !== 24'd10) begin $display("FAIL idle_tw: got %0d expected 10", tuning_word); err_cnt++; end
      vec_cnt++; if ({tw_valid, learn_mode, sweep_done} !== 3'b000) begin $display("FAIL idle_flags: got %b expected 000", {tw_valid, learn_mode, sweep_done}); err_cnt++; end
   endtask

   task automatic test_fine_up();
      for (int i = 0; i < 29; i++) press(2'b10);
      vec_cnt++; if (freq_out !== 16'd30) begin $display("FAIL fine_top: got %0d expected 30", freq_out); err_cnt++; end
      key = 2'b01;
      wait_neg(2);
      vec_cnt++; if (freq_out !== 16'd30) begin $display("FAIL latency_early: got %0d expected 30", freq_out); err_cnt++; end
      wait_neg(1);
      vec_cnt++; if (freq_out !== 16'd15000) begin $display("FAIL fine_to_coarse: got %0d expected 15000", freq_out); err_cnt++; end
      vec_cnt++; if (tuning_word !== 24'd308) begin $display("FAIL tw_lag: got %0d expected 308", tuning_word); err_cnt++; end
      wait_neg(1);
      vec_cnt++; if (tuning_word !== 24'd153750) begin $display("FAIL tw_15000: got %0d expected 153750", tuning_word); err_cnt++; end
      vec_cnt++; if (tw_valid !== 1'b1) begin $display("FAIL tw_valid_pulse: got %b expected 1", tw_valid); err_cnt++; end
      wait_neg(1);
      vec_cnt++; if (tw_valid !== 1'b0) begin $display("FAIL tw_valid_end: got %b expected 0", tw_valid); err_cnt++; end
      key = 2'b11;
      wait_neg(4);
   endtask

   task automatic test_learn();
      learn_en = 1'b1;
      wait_neg(2);
      vec_cnt++; if (learn_mode !== 1'b0) begin $display("FAIL learn_early: got %b expected 0", learn_mode); err_cnt++; end
      wait_neg(1);
      vec_cnt++; if (freq_out !== 16'd1000) begin $display("FAIL learn_load: got %0d expected 1000", freq_out); err_cnt++; end
      vec_cnt++; if (learn_mode !== 1'b1) begin $display("FAIL learn_mode_on: got %b expected 1", learn_mode); err_cnt++; end
      wait_neg(1);
      vec_cnt++; if (tuning_word !== 24'd10250) begin $display("FAIL tw_1000: got %0d expected 10250", tuning_word); err_cnt++; end
      wait_neg(4);
      for (int i = 0; i < 3; i++) pulse_next();
      vec_cnt++; if (freq_out !== 16'd1006) begin $display("FAIL sweep_3: got %0d expected 1006", freq_out); err_cnt++; end
      learn_en = 1'b0;
      wait_neg(3);
      vec_cnt++; if (freq_out !== 16'd15000) begin $display("FAIL learn_restore: got %0d expected 15000", freq_out); err_cnt++; end
      vec_cnt++; if (learn_mode !== 1'b0) begin $display("FAIL learn_mode_off: got %b expected 0", learn_mode); err_cnt++; end
      wait_neg(3);
   endtask

   task automatic test_sweep_stop();
      learn_en = 1'b1;
      wait_neg(6);
      for (int i = 0; i < 4; i++) pulse_next();
      vec_cnt++; if ({sweep_done_s, freq_out_s} !== {1'b0, 16'd1008}) begin $display("FAIL stop_4: got done=%b freq=%0d expected done=0 freq=1008", sweep_done_s, freq_out_s); err_cnt++; end
      next_freq = 1'b1;
      wait_neg(2);
      vec_cnt++; if (sweep_done_s !== 1'b0) begin $display("FAIL stop_done_early: got %b expected 0", sweep_done_s); err_cnt++; end
      wait_neg(1);
      vec_cnt++; if ({sweep_done_s, freq_out_s} !== {1'b1, 16'd1010}) begin $display("FAIL stop_5: got done=%b freq=%0d expected done=1 freq=1010", sweep_done_s, freq_out_s); err_cnt++; end
      wait_neg(1);
      next_freq = 1'b0;
      wait_neg(4);
      pulse_next();
      vec_cnt++; if ({sweep_done_s, freq_out_s} !== {1'b1, 16'd1010}) begin $display("FAIL stop_6: got done=%b freq=%0d expected done=1 freq=1010", sweep_done_s, freq_out_s); err_cnt++; end
      vec_cnt++; if ({sweep_done, freq_out} !== {1'b0, 16'd1012}) begin $display("FAIL nostop_6: got done=%b freq=%0d expected done=0 freq=1012", sweep_done, freq_out); err_cnt++; end
      learn_en = 1'b0;
      wait_neg(3);
      vec_cnt++; if ({sweep_done_s, freq_out_s} !== {1'b0, 16'd15000}) begin $display("FAIL stop_exit: got done=%b freq=%0d expected done=0 freq=15000", sweep_done_s, freq_out_s); err_cnt++; end
      wait_neg(3);
   endtask

   task automatic test_coarse_top();
      press(2'b01);
      vec_cnt++; if (freq_out !== 16'd30) begin $display("FAIL coarse_down_fine: got %0d expected 30", freq_out); err_cnt++; end
      press(2'b10);
      press(2'b10);
      vec_cnt++; if (freq_out !== 16'd30000) begin $display("FAIL coarse_2: got %0d expected 30000", freq_out); err_cnt++; end
      press(2'b10);
      vec_cnt++; if (freq_out !== 16'd45000) begin $display("FAIL coarse_3: got %0d expected 45000", freq_out); err_cnt++; end
      key = 2'b01;
      wait_neg(3);
      vec_cnt++; if (freq_out !== 16'd45000) begin $display("FAIL coarse_hold: got %0d expected 45000", freq_out); err_cnt++; end
      wait_neg(1);
      vec_cnt++; if (tuning_word !== 24'd461250) begin $display("FAIL tw_45000: got %0d expected 461250", tuning_word); err_cnt++; end
      vec_cnt++; if (tw_valid !== 1'b0) begin $display("FAIL hold_no_valid: got %b expected 0", tw_valid); err_cnt++; end
      key = 2'b11;
      wait_neg(4);
      press(2'b01);
      vec_cnt++; if (freq_out !== 16'd30000) begin $display("FAIL coarse_down: got %0d expected 30000", freq_out); err_cnt++; end
      press(2'b01);
      vec_cnt++; if (freq_out !== 16'd15000) begin $display("FAIL coarse_down2: got %0d expected 15000", freq_out); err_cnt++; end
   endtask

   task automatic test_down_wrap();
      do_reset();
      press(2'b01);
      vec_cnt++; if (freq_out !== 16'd30) begin $display("FAIL down_wrap: got %0d expected 30", freq_out); err_cnt++; end
   endtask

   task automatic test_learn_keys();
      press(2'b11);
      vec_cnt++; if (freq_out !== 16'd29) begin $display("FAIL both_down_wins: got %0d expected 29", freq_out); err_cnt++; end
      learn_en = 1'b1;
      key = 2'b01;
      wait_neg(3);
      vec_cnt++; if ({learn_mode, freq_out} !== {1'b1, 16'd1000}) begin $display("FAIL learn_beats_key: got mode=%b freq=%0d expected mode=1 freq=1000", learn_mode, freq_out); err_cnt++; end
      wait_neg(1);
      key = 2'b11;
      wait_neg(4);
      press(2'b11);
      vec_cnt++; if (freq_out !== 16'd1000) begin $display("FAIL learn_keys_ignored: got %0d expected 1000", freq_out); err_cnt++; end
      pulse_next();
      vec_cnt++; if (freq_out !== 16'd1002) begin $display("FAIL learn_step: got %0d expected 1002", freq_out); err_cnt++; end
      learn_en = 1'b0;
      next_freq = 1'b1;
      wait_neg(3);
      vec_cnt++; if ({learn_mode, freq_out} !== {1'b0, 16'd29}) begin $display("FAIL restore_wins: got mode=%b freq=%0d expected mode=0 freq=29", learn_mode, freq_out); err_cnt++; end
      wait_neg(1);
      next_freq = 1'b0;
      wait_neg(4);
      vec_cnt++; if (freq_out !== 16'd29) begin $display("FAIL restore_stable: got %0d expected 29", freq_out); err_cnt++; end
   endtask

   task automatic test_reset_mid_sweep();
      learn_en = 1'b1;
      wait_neg(6);
      pulse_next();
      pulse_next();
      vec_cnt++; if (freq_out !== 16'd1004) begin $display("FAIL mid_sweep: got %0d expected 1004", freq_out); err_cnt++; end
      rst_n = 1'b0;
      learn_en = 1'b0;
      wait_neg(1);
      vec_cnt++; if ({learn_mode, freq_out} !== {1'b0, 16'd1}) begin $display("FAIL mid_rst: got mode=%b freq=%0d expected mode=0 freq=1", learn_mode, freq_out); err_cnt++; end
      wait_neg(1);
      rst_n = 1'b1;
      wait_neg(2);
      vec_cnt++; if (tuning_word !== 24'd10) begin $display("FAIL mid_rst_tw: got %0d expected 10", tuning_word); err_cnt++; end
      press(2'b01);
      vec_cnt++; if ({learn_mode, freq_out} !== {1'b0, 16'd30}) begin $display("FAIL post_rst_down: got mode=%b freq=%0d expected mode=0 freq=30", learn_mode, freq_out); err_cnt++; end
   endtask

   initial begin
      rst_n     = 1'b0;
      key       = 2'b11;
      learn_en  = 1'b0;
      next_freq = 1'b0;
      wait_neg(1);
      test_reset();
      test_fine_up();
      test_learn();
      test_sweep_stop();
      test_coarse_top();
      test_down_wrap();
      test_learn_keys();
      test_reset_mid_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
